// File: rtl/mem_stage_lsu_if.sv
// MEM-stage bundle: EX/MEM-side request fields in, MEM/WB-side results out.
// The pipeline drives through "master"; the load/store unit sits on "slave".
interface mem_stage_lsu_if #(
    parameter int XLEN = 64
);
    logic            ValidM;
    logic            StallM;
    logic            RegWriteEnM;
    logic            MemtoRegM;
    logic            JALM;
    logic            MemReadEnM;
    logic            MemWriteEnM;
    logic [1:0]      MemSizeM;
    logic            LoadUnsignedM;
    logic [4:0]      RdM;
    logic [XLEN-1:0] PcPlus4M;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] ReadData2M;

    logic            RegWriteEnW;
    logic            MemtoRegW;
    logic            JALW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] PcPlus4W;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic            MisalignW;

    modport master (
        output ValidM, StallM, RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM,
               MemSizeM, LoadUnsignedM, RdM, PcPlus4M, ALUResultM, ReadData2M,
        input  RegWriteEnW, MemtoRegW, JALW, RdW, PcPlus4W, ALUResultW, ReadDataW, MisalignW
    );

    modport slave (
        input  ValidM, StallM, RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM,
               MemSizeM, LoadUnsignedM, RdM, PcPlus4M, ALUResultM, ReadData2M,
        output RegWriteEnW, MemtoRegW, JALW, RdW, PcPlus4W, ALUResultW, ReadDataW, MisalignW
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Load/store MEM stage with byte-lane data RAM and a uniform one-cycle latency to WB.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them down.
module mem_stage_lsu #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024
) (
    input logic            clk,
    input logic            rst,
    mem_stage_lsu_if.slave bus
);
    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int IDXW  = $clog2(DEPTH);

    logic [XLEN-1:0] ram [DEPTH];

    logic [OFFW-1:0] offset;
    logic [OFFW-1:0] off_eff;
    logic [OFFW-1:0] size_mask;
    logic [1:0]      size_eff;
    logic [IDXW-1:0] word_idx;
    logic [LANES-1:0] byte_en;
    logic [XLEN-1:0] wr_data;
    logic            wr_en;
    logic            misalign;

    logic            regwrite_d, regwrite_q;
    logic            memtoreg_d, memtoreg_q;
    logic            jal_d, jal_q;
    logic [4:0]      rd_d, rd_q;
    logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic            misalign_d, misalign_q;
    logic [XLEN-1:0] rdata_d, rdata_q;
    logic            ld_en_d, ld_en_q;
    logic [1:0]      ld_size_d, ld_size_q;
    logic [OFFW-1:0] ld_off_d, ld_off_q;
    logic            ld_uns_d, ld_uns_q;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    // Address bits above the word index are deliberately ignored (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ALUResultM[XLEN-1:OFFW+IDXW];

    always_comb begin
        offset    = bus.ALUResultM[OFFW-1:0];
        word_idx  = bus.ALUResultM[OFFW +: IDXW];
        size_eff  = (XLEN == 32 && bus.MemSizeM == 2'b11) ? 2'b10 : bus.MemSizeM;
        size_mask = OFFW'((4'd1 << size_eff) - 4'd1);
`ifdef MEM_MISALIGN_TRAP_EN
        misalign  = bus.ValidM && (bus.MemReadEnM || bus.MemWriteEnM) &&
                    ((offset & size_mask) != '0);
        off_eff   = offset;
`else
        misalign  = 1'b0;
        off_eff   = offset & ~size_mask;
`endif
        for (int k = 0; k < LANES; k++) begin
            byte_en[k] = (k >= int'(off_eff)) && (k <= int'(off_eff | size_mask));
        end
        wr_data = bus.ReadData2M << {off_eff, 3'b000};
        wr_en   = bus.ValidM && bus.MemWriteEnM && !bus.StallM && !rst && !misalign;
    end

    always_comb begin
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        jal_d        = jal_q;
        rd_d         = rd_q;
        pc_plus4_d   = pc_plus4_q;
        alu_result_d = alu_result_q;
        misalign_d   = misalign_q;
        rdata_d      = rdata_q;
        ld_en_d      = ld_en_q;
        ld_size_d    = ld_size_q;
        ld_off_d     = ld_off_q;
        ld_uns_d     = ld_uns_q;
        if (!bus.StallM) begin
            regwrite_d   = bus.ValidM && bus.RegWriteEnM && !(misalign && bus.MemReadEnM);
            memtoreg_d   = bus.ValidM && bus.MemtoRegM;
            jal_d        = bus.ValidM && bus.JALM;
            rd_d         = bus.RdM;
            pc_plus4_d   = bus.PcPlus4M;
            alu_result_d = bus.ALUResultM;
            misalign_d   = misalign;
            rdata_d      = ram[word_idx];
            ld_en_d      = bus.ValidM && bus.MemReadEnM && !misalign;
            ld_size_d    = size_eff;
            ld_off_d     = off_eff;
            ld_uns_d     = bus.LoadUnsignedM;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (byte_en[k]) ram[word_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            jal_q        <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            alu_result_q <= '0;
            misalign_q   <= 1'b0;
            rdata_q      <= '0;
            ld_en_q      <= 1'b0;
            ld_size_q    <= '0;
            ld_off_q     <= '0;
            ld_uns_q     <= 1'b0;
        end else begin
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            jal_q        <= jal_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            alu_result_q <= alu_result_d;
            misalign_q   <= misalign_d;
            rdata_q      <= rdata_d;
            ld_en_q      <= ld_en_d;
            ld_size_q    <= ld_size_d;
            ld_off_q     <= ld_off_d;
            ld_uns_q     <= ld_uns_d;
        end
    end

    // Load formatting works purely on registered state, so no M input reaches WB combinationally.
    always_comb begin
        shifted = rdata_q >> {ld_off_q, 3'b000};
        case (ld_size_q)
            2'b00:   load_data = ld_uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'b01:   load_data = ld_uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'b10:   load_data = ld_uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: load_data = shifted;
        endcase
        if (!ld_en_q) load_data = '0;
    end

    assign bus.RegWriteEnW = regwrite_q;
    assign bus.MemtoRegW   = memtoreg_q;
    assign bus.JALW        = jal_q;
    assign bus.RdW         = rd_q;
    assign bus.PcPlus4W    = pc_plus4_q;
    assign bus.ALUResultW  = alu_result_q;
    assign bus.ReadDataW   = load_data;
    assign bus.MisalignW   = misalign_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=64, DEPTH=1024); expectations follow MEM_MISALIGN_TRAP_EN.
module tb_mem_stage_lsu;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(64)) bus ();

    mem_stage_lsu #(.XLEN(64), .DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one M-side slot, then returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic valid, input logic stall, input logic rd_en,
                                 input logic wr_en, input logic reg_wr, input logic [1:0] size,
                                 input logic uns, input logic [63:0] addr, input logic [63:0] data);
        bus.ValidM        = valid;
        bus.StallM        = stall;
        bus.MemReadEnM    = rd_en;
        bus.MemWriteEnM   = wr_en;
        bus.RegWriteEnM   = reg_wr;
        bus.MemtoRegM     = rd_en;
        bus.JALM          = 1'b0;
        bus.MemSizeM      = size;
        bus.LoadUnsignedM = uns;
        bus.RdM           = reg_wr ? 5'd10 : 5'd0;
        bus.PcPlus4M      = addr + 64'd4;
        bus.ALUResultM    = addr;
        bus.ReadData2M    = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
        checkOutput("rst_regwrite", 64'(bus.RegWriteEnW), 64'd0);
        checkOutput("rst_readdata", bus.ReadDataW, 64'd0);
        checkOutput("rst_misalign", 64'(bus.MisalignW), 64'd0);
        checkOutput("rst_jal",      64'(bus.JALW), 64'd0);
        rst = 1'b0;

        // valid stall rd wr regw size uns addr data
        applyStimulus(1, 0, 0, 1, 0, 2'b11, 0, 64'h10, 64'h8877665544332211);
        checkOutput("sd_regwrite", 64'(bus.RegWriteEnW), 64'd0);
        checkOutput("sd_readdata", bus.ReadDataW, 64'd0);

        applyStimulus(1, 0, 1, 0, 1, 2'b11, 0, 64'h10, 64'h0);
        checkOutput("ld_data",     bus.ReadDataW, 64'h8877665544332211);
        checkOutput("ld_regwrite", 64'(bus.RegWriteEnW), 64'd1);
        checkOutput("ld_memtoreg", 64'(bus.MemtoRegW), 64'd1);
        checkOutput("ld_rd",       64'(bus.RdW), 64'd10);
        checkOutput("ld_pc4",      bus.PcPlus4W, 64'h14);
        checkOutput("ld_alu",      bus.ALUResultW, 64'h10);

        applyStimulus(1, 0, 0, 1, 0, 2'b00, 0, 64'h13, 64'h123456789ABCDEF0);
        applyStimulus(1, 0, 1, 0, 1, 2'b00, 0, 64'h13, 64'h0);
        checkOutput("lb_signed",   bus.ReadDataW, 64'hFFFFFFFFFFFFFFF0);
        applyStimulus(1, 0, 1, 0, 1, 2'b00, 1, 64'h13, 64'h0);
        checkOutput("lbu",         bus.ReadDataW, 64'h00000000000000F0);
        applyStimulus(1, 0, 1, 0, 1, 2'b11, 0, 64'h10, 64'h0);
        checkOutput("sb_neighbors", bus.ReadDataW, 64'h88776655F0332211);

        applyStimulus(1, 0, 0, 1, 0, 2'b01, 0, 64'h16, 64'hFFFFFFFFFFFF8001);
        applyStimulus(1, 0, 1, 0, 1, 2'b01, 0, 64'h16, 64'h0);
        checkOutput("lh_signed",   bus.ReadDataW, 64'hFFFFFFFFFFFF8001);
        applyStimulus(1, 0, 1, 0, 1, 2'b01, 1, 64'h16, 64'h0);
        checkOutput("lhu",         bus.ReadDataW, 64'h0000000000008001);
        applyStimulus(1, 0, 1, 0, 1, 2'b10, 1, 64'h14, 64'h0);
        checkOutput("lwu",         bus.ReadDataW, 64'h0000000080016655);
        applyStimulus(1, 0, 1, 0, 1, 2'b10, 0, 64'h14, 64'h0);
        checkOutput("lw_signed",   bus.ReadDataW, 64'hFFFFFFFF80016655);

        applyStimulus(1, 0, 1, 0, 1, 2'b10, 0, 64'h10, 64'h0);
        checkOutput("stall_lw",    bus.ReadDataW, 64'hFFFFFFFFF0332211);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 2'b10, 0, 64'h10, 64'h00000000DEADBEEF);
            checkOutput("stall_hold_data", bus.ReadDataW, 64'hFFFFFFFFF0332211);
            checkOutput("stall_hold_rw",   64'(bus.RegWriteEnW), 64'd1);
        end
        applyStimulus(1, 0, 0, 1, 0, 2'b10, 0, 64'h10, 64'h00000000DEADBEEF);
        checkOutput("release_rw",  64'(bus.RegWriteEnW), 64'd0);
        applyStimulus(1, 0, 1, 0, 1, 2'b10, 0, 64'h10, 64'h0);
        checkOutput("release_commit", bus.ReadDataW, 64'hFFFFFFFFDEADBEEF);

        applyStimulus(1, 1, 0, 1, 0, 2'b10, 0, 64'h10, 64'h0000000011111111);
        checkOutput("stall_no_write_hold", bus.ReadDataW, 64'hFFFFFFFFDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 64'h0, 64'h0);
        applyStimulus(1, 0, 1, 0, 1, 2'b10, 1, 64'h10, 64'h0);
        checkOutput("stall_no_write", bus.ReadDataW, 64'h00000000DEADBEEF);

        applyStimulus(1, 0, 1, 0, 1, 2'b10, 0, 64'h12, 64'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("mis_lw_flag", 64'(bus.MisalignW), 64'd1);
        checkOutput("mis_lw_rw",   64'(bus.RegWriteEnW), 64'd0);
        checkOutput("mis_lw_data", bus.ReadDataW, 64'd0);
`else
        checkOutput("mis_lw_flag", 64'(bus.MisalignW), 64'd0);
        checkOutput("mis_lw_rw",   64'(bus.RegWriteEnW), 64'd1);
        checkOutput("mis_lw_data", bus.ReadDataW, 64'hFFFFFFFFDEADBEEF);
`endif

        applyStimulus(1, 0, 0, 1, 0, 2'b11, 0, 64'h20, 64'h0);
        applyStimulus(1, 0, 0, 1, 0, 2'b10, 0, 64'h21, 64'h00000000CAFEBABE);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("mis_sw_flag", 64'(bus.MisalignW), 64'd1);
`else
        checkOutput("mis_sw_flag", 64'(bus.MisalignW), 64'd0);
`endif
        applyStimulus(1, 0, 1, 0, 1, 2'b11, 0, 64'h20, 64'h0);
        checkOutput("mis_flag_clear", 64'(bus.MisalignW), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("mis_sw_mem", bus.ReadDataW, 64'h0);
`else
        checkOutput("mis_sw_mem", bus.ReadDataW, 64'h00000000CAFEBABE);
`endif

        applyStimulus(0, 0, 0, 1, 1, 2'b11, 0, 64'h20, 64'hFFFFFFFFFFFFFFFF);
        checkOutput("bubble_rw",   64'(bus.RegWriteEnW), 64'd0);
        checkOutput("bubble_m2r",  64'(bus.MemtoRegW), 64'd0);
        applyStimulus(1, 0, 1, 0, 1, 2'b11, 0, 64'h20, 64'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("bubble_no_write", bus.ReadDataW, 64'h0);
`else
        checkOutput("bubble_no_write", bus.ReadDataW, 64'h00000000CAFEBABE);
`endif

        applyStimulus(1, 0, 1, 0, 1, 2'b11, 0, 64'h2010, 64'h0);
        checkOutput("addr_wrap", bus.ReadDataW, 64'h80016655DEADBEEF);

        rst = 1'b1;
        applyStimulus(1, 1, 1, 0, 1, 2'b11, 0, 64'h10, 64'h0);
        checkOutput("midrst_data", bus.ReadDataW, 64'd0);
        checkOutput("midrst_rw",   64'(bus.RegWriteEnW), 64'd0);
        checkOutput("midrst_pc4",  bus.PcPlus4W, 64'd0);
        checkOutput("midrst_rd",   64'(bus.RdW), 64'd0);
        rst = 1'b0;
        applyStimulus(1, 0, 1, 0, 1, 2'b11, 0, 64'h10, 64'h0);
        checkOutput("post_rst_ld", bus.ReadDataW, 64'h80016655DEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
